// File: rtl/uart_rx_frame_ctrl.sv
// Frame controller behind the UART receiver: SYNC, LEN, payload, CHK; payload released only on good checksum.
// Status ticks one cycle after the causing byte/timeout; drain stalls indefinitely on out_ready low, bytes arriving meanwhile are dropped.
module uart_rx_frame_ctrl #(
  parameter logic [7:0] SYNC          = 8'hA5,
  parameter int         MAX_LEN       = 16,
  parameter int         TIMEOUT_TICKS = 160
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_done_tick,
  input  logic [7:0] din,
  input  logic       s_tick,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic       frame_ok_tick,
  output logic       chk_err_tick,
  output logic       len_err_tick,
  output logic       timeout_tick,
  output logic       ovr_tick,
  output logic       busy
);

  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TW = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_TICKS - 1);

  typedef enum logic [2:0] {HUNT, LEN, PAYLOAD, CHK, DRAIN} state_t;

  state_t        state;
  logic [LW-1:0] len, wr_ptr, rd_ptr;
  logic [7:0]    sum;
  logic [TW-1:0] to_cnt;
  logic [7:0]    buf_mem [2**IW];

  logic [LW-1:0] len_m1, rd_nxt;
  logic [7:0]    chk_sum;
  logic          in_frame, to_expire, xfer, buf_we;

  assign len_m1    = len - LW'(1);
  assign rd_nxt    = rd_ptr + LW'(1);
  assign chk_sum   = sum + din;
  assign in_frame  = (state == LEN) || (state == PAYLOAD) || (state == CHK);
  // A byte arriving on the expiring tick wins over the timeout.
  assign to_expire = in_frame && s_tick && !rx_done_tick && (to_cnt == TO_LAST);
  assign xfer      = out_valid && out_ready;
  assign buf_we    = (state == PAYLOAD) && rx_done_tick;

  always_ff @(posedge clk) begin
    if (buf_we) buf_mem[wr_ptr[IW-1:0]] <= din;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= HUNT;
      len           <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      sum           <= '0;
      to_cnt        <= '0;
      out_data      <= '0;
      out_valid     <= 1'b0;
      out_last      <= 1'b0;
      frame_ok_tick <= 1'b0;
      chk_err_tick  <= 1'b0;
      len_err_tick  <= 1'b0;
      timeout_tick  <= 1'b0;
      ovr_tick      <= 1'b0;
      busy          <= 1'b0;
    end else begin
      frame_ok_tick <= 1'b0;
      chk_err_tick  <= 1'b0;
      len_err_tick  <= 1'b0;
      timeout_tick  <= 1'b0;
      ovr_tick      <= 1'b0;

      if (in_frame) begin
        if (rx_done_tick)  to_cnt <= '0;
        else if (s_tick)   to_cnt <= to_cnt + TW'(1);
      end

      if (to_expire) begin
        timeout_tick <= 1'b1;
        state        <= HUNT;
        busy         <= 1'b0;
        to_cnt       <= '0;
      end else begin
        case (state)
          HUNT: begin
            if (rx_done_tick && din == SYNC) begin
              state  <= LEN;
              busy   <= 1'b1;
              to_cnt <= '0;
            end
          end
          LEN: begin
            if (rx_done_tick) begin
              if (din != 8'd0 && din <= MAX_LEN_B) begin
                len    <= din[LW-1:0];
                sum    <= din;
                wr_ptr <= '0;
                state  <= PAYLOAD;
              end else begin
                len_err_tick <= 1'b1;
                state        <= HUNT;
                busy         <= 1'b0;
              end
            end
          end
          PAYLOAD: begin
            if (rx_done_tick) begin
              sum    <= chk_sum;
              wr_ptr <= wr_ptr + LW'(1);
              if (wr_ptr == len_m1) state <= CHK;
            end
          end
          CHK: begin
            if (rx_done_tick) begin
              if (chk_sum == 8'd0) begin
                frame_ok_tick <= 1'b1;
                rd_ptr        <= '0;
                state         <= DRAIN;
                out_valid     <= 1'b1;
                out_data      <= buf_mem[IW'(0)];
                out_last      <= (len_m1 == '0);
              end else begin
                chk_err_tick <= 1'b1;
                state        <= HUNT;
                busy         <= 1'b0;
              end
            end
          end
          DRAIN: begin
            if (rx_done_tick) ovr_tick <= 1'b1;
            if (xfer) begin
              if (out_last) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
                state     <= HUNT;
                busy      <= 1'b0;
              end else begin
                rd_ptr   <= rd_nxt;
                out_data <= buf_mem[rd_nxt[IW-1:0]];
                out_last <= (rd_nxt == len_m1);
              end
            end
          end
          default: begin
            state <= HUNT;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Directed bench for uart_rx_frame_ctrl with a frame-level reference model and per-cycle output compare.
module tb_uart_rx_frame_ctrl;

  localparam logic [7:0] SYNC          = 8'hA5;
  localparam int         MAX_LEN       = 16;
  localparam int         TIMEOUT_TICKS = 160;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx_done_tick;
  logic [7:0] din;
  logic       s_tick;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
  logic       frame_ok_tick, chk_err_tick, len_err_tick, timeout_tick, ovr_tick;
  logic       busy;

  uart_rx_frame_ctrl #(
    .SYNC(SYNC), .MAX_LEN(MAX_LEN), .TIMEOUT_TICKS(TIMEOUT_TICKS)
  ) dut (
    .clk(clk), .reset(reset), .rx_done_tick(rx_done_tick), .din(din), .s_tick(s_tick),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .frame_ok_tick(frame_ok_tick), .chk_err_tick(chk_err_tick), .len_err_tick(len_err_tick),
    .timeout_tick(timeout_tick), .ovr_tick(ovr_tick), .busy(busy)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: bytes after SYNC are collected; a frame is judged once LEN+2 bytes are in.
  logic [7:0] frame_q[$];
  logic [8:0] exp_out[$];   // {last, data}
  logic [4:0] exp_ticks = '0;   // {ovr, timeout, len_err, chk_err, ok}
  bit         m_in_frame = 1'b0;
  int         tick_cnt = 0;

  function automatic void model_byte(input logic [7:0] b);
    int l, s;
    tick_cnt = 0;
    if (exp_out.size() > 0) begin
      exp_ticks[4] = 1'b1;
      return;
    end
    if (!m_in_frame) begin
      if (b == SYNC) begin
        m_in_frame = 1'b1;
        frame_q.delete();
      end
      return;
    end
    frame_q.push_back(b);
    l = int'(frame_q[0]);
    if (l == 0 || l > MAX_LEN) begin
      exp_ticks[2] = 1'b1;
      m_in_frame = 1'b0;
      return;
    end
    if (frame_q.size() == l + 2) begin
      s = 0;
      foreach (frame_q[i]) s += int'(frame_q[i]);
      if (s % 256 == 0) begin
        exp_ticks[0] = 1'b1;
        for (int i = 1; i <= l; i++) exp_out.push_back({(i == l), frame_q[i]});
      end else begin
        exp_ticks[1] = 1'b1;
      end
      m_in_frame = 1'b0;
    end
  endfunction

  function automatic void model_stick();
    if (m_in_frame) begin
      tick_cnt++;
      if (tick_cnt == TIMEOUT_TICKS) begin
        exp_ticks[3] = 1'b1;
        m_in_frame = 1'b0;
      end
    end
  endfunction

  function automatic void model_reset();
    m_in_frame = 1'b0;
    tick_cnt = 0;
    exp_out.delete();
    frame_q.delete();
    exp_ticks = '0;
  endfunction

  // Compare process: one sample per cycle, just after the rising edge.
  logic [4:0] dut_ticks;
  assign dut_ticks = {ovr_tick, timeout_tick, len_err_tick, chk_err_tick, frame_ok_tick};
  logic [8:0] out_log[$];
  int n_ok = 0, n_chk = 0, n_len = 0, n_to = 0, n_ovr = 0;
  logic       prev_valid = 1'b0;
  logic [8:0] prev_beat = '0;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!reset && prev_valid && out_ready) begin
        out_log.push_back(prev_beat);
        if (exp_out.size() == 0) chk("unexpected_xfer", 32'(prev_beat), 32'h1ff);
        else void'(exp_out.pop_front());
      end
      chk("out_valid", 32'(out_valid), 32'(exp_out.size() > 0));
      if (out_valid && exp_out.size() > 0) begin
        chk("out_data", 32'(out_data), 32'(exp_out[0][7:0]));
        chk("out_last", 32'(out_last), 32'(exp_out[0][8]));
      end
      chk("busy", 32'(busy), 32'(m_in_frame || exp_out.size() > 0));
      chk("status_ticks", 32'(dut_ticks), 32'(exp_ticks));
      exp_ticks = '0;
      n_ok  += int'(frame_ok_tick);
      n_chk += int'(chk_err_tick);
      n_len += int'(len_err_tick);
      n_to  += int'(timeout_tick);
      n_ovr += int'(ovr_tick);
      prev_valid = out_valid;
      prev_beat  = {out_last, out_data};
    end
  end

  task automatic step(input bit rx, input logic [7:0] b, input bit st, input bit rdy);
    @(negedge clk);
    rx_done_tick = rx;
    din          = rx ? b : 8'h00;
    s_tick       = st;
    out_ready    = rdy;
    if (rx) model_byte(b);
    else if (st) model_stick();
  endtask

  logic [7:0] txq[$];

  task automatic send_txq(input bit rdy);
    foreach (txq[i]) step(1'b1, txq[i], 1'b0, rdy);
    step(1'b0, 8'h00, 1'b0, rdy);
  endtask

  task automatic wait_drain();
    bit done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      if (exp_out.size() == 0 && !out_valid) done = 1'b1;
      else step(1'b0, 8'h00, 1'b0, 1'b1);
    end
    if (!done) chk("drain_budget", 32'd0, 32'd1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
  endtask

  initial begin
    reset = 1'b1;
    rx_done_tick = 1'b0;
    din = 8'h00;
    s_tick = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_ticks", 32'(dut_ticks), 32'd0);
    reset = 1'b0;
    step(1'b0, 8'h00, 1'b0, 1'b1);

    // Good frame
    txq = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h97};
    send_txq(1'b1);
    wait_drain();
    chk("good_ok_count", 32'(n_ok), 32'd1);
    chk("good_out_count", 32'(out_log.size()), 32'd3);
    chk("good_beat0", 32'(out_log[0]), 32'h011);
    chk("good_beat1", 32'(out_log[1]), 32'h022);
    chk("good_beat2_last", 32'(out_log[2]), 32'h133);
    chk("good_busy_after", 32'(busy), 32'd0);

    // Bad checksum, then a good frame
    txq = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h98};
    send_txq(1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("bad_chk_count", 32'(n_chk), 32'd1);
    chk("bad_no_output", 32'(out_log.size()), 32'd3);
    txq = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h97};
    send_txq(1'b1);
    wait_drain();
    chk("after_bad_ok_count", 32'(n_ok), 32'd2);

    // Length errors, leading garbage, LEN equal to SYNC
    txq = '{8'h00, 8'hFF, 8'hA5, 8'h00, 8'hA5, 8'h11, 8'hA5, 8'hA5};
    send_txq(1'b1);
    chk("len_err_count", 32'(n_len), 32'd3);
    chk("len_err_busy", 32'(busy), 32'd0);

    // LEN=1 and LEN=MAX_LEN boundaries
    txq = '{8'hA5, 8'h01, 8'h7F, 8'h80};
    send_txq(1'b1);
    wait_drain();
    chk("len1_beat", 32'(out_log[6]), 32'h17F);
    txq = '{8'hA5, 8'h10};
    for (int i = 0; i < 16; i++) txq.push_back(8'h01);
    txq.push_back(8'hE0);
    send_txq(1'b1);
    wait_drain();
    chk("maxlen_ok_count", 32'(n_ok), 32'd4);
    chk("maxlen_out_count", 32'(out_log.size()), 32'd23);
    chk("maxlen_last_beat", 32'(out_log[22]), 32'h101);

    // Inter-byte timeout, then a stray byte in HUNT
    txq = '{8'hA5, 8'h02, 8'h11};
    send_txq(1'b1);
    repeat (TIMEOUT_TICKS) step(1'b0, 8'h00, 1'b1, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("timeout_count", 32'(n_to), 32'd1);
    chk("timeout_busy", 32'(busy), 32'd0);
    step(1'b1, 8'h22, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("stray_busy", 32'(busy), 32'd0);

    // Byte lands on the expiring tick: byte wins
    txq = '{8'hA5, 8'h02, 8'h11};
    send_txq(1'b1);
    repeat (TIMEOUT_TICKS - 1) step(1'b0, 8'h00, 1'b1, 1'b1);
    step(1'b1, 8'h22, 1'b1, 1'b1);
    step(1'b1, 8'hCB, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    wait_drain();
    chk("race_timeout_count", 32'(n_to), 32'd1);
    chk("race_ok_count", 32'(n_ok), 32'd5);
    chk("race_last_beat", 32'(out_log[24]), 32'h122);

    // Backpressure with an overrun SYNC during the stall
    txq = '{8'hA5, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'hF2};
    send_txq(1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b1, 8'hA5, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    wait_drain();
    chk("ovr_count", 32'(n_ovr), 32'd1);
    chk("bp_beat0", 32'(out_log[25]), 32'h001);
    chk("bp_beat1", 32'(out_log[26]), 32'h002);
    chk("bp_beat2", 32'(out_log[27]), 32'h003);
    chk("bp_beat3_last", 32'(out_log[28]), 32'h104);
    step(1'b1, 8'h03, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("no_restart_busy", 32'(busy), 32'd0);

    // Async reset mid-payload
    txq = '{8'hA5, 8'h03, 8'h11};
    send_txq(1'b1);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    #1;
    chk("async_reset_busy", 32'(busy), 32'd0);
    chk("async_reset_valid", 32'(out_valid), 32'd0);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    @(negedge clk);
    reset = 1'b0;
    step(1'b0, 8'h00, 1'b0, 1'b1);
    txq = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h97};
    send_txq(1'b1);
    wait_drain();
    chk("post_reset_ok_count", 32'(n_ok), 32'd7);
    chk("post_reset_last_beat", 32'(out_log[31]), 32'h133);
    chk("total_chk_errs", 32'(n_chk), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
